// File: rtl/lt100_bus_arbiter.sv
// rtl/lt100_bus_arbiter.sv - two-master round-robin arbiter for the lt100 enable/ready bus
//
// Purpose: lets master 0 (CPU) and master 1 (DMA/debug loader) share one lt100 slave port.
// Transactions are serialised with round-robin priority. s_enable is always low for at least
// one cycle between transactions. A per-transaction timeout frees the bus if the slave never
// answers.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   mN_enable/wr_en/addr/i_data/be  master N request (N = 0, 1), held until mN_ready
//   mN_ready/o_data/err           master N completion, held until mN_enable drops
//   s_enable/wr_en/addr/i_data/be slave request, registered
//   s_ready/o_data/err            slave completion
//   grant                         master owning the current or last transaction
//   busy                          high whenever the arbiter is not idle
module lt100_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_enable,
    input  logic              m0_wr_en,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_i_data,
    input  logic [BE_W-1:0]   m0_be,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_o_data,
    output logic              m0_err,

    input  logic              m1_enable,
    input  logic              m1_wr_en,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_i_data,
    input  logic [BE_W-1:0]   m1_be,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_o_data,
    output logic              m1_err,

    output logic              s_enable,
    output logic              s_wr_en,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_i_data,
    output logic [BE_W-1:0]   s_be,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_o_data,
    input  logic              s_err,

    output logic              grant,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit               TO_EN    = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [1:0]       state;
    logic             last_grant;
    logic [CNT_W-1:0] to_cnt;

    // Arbitration decision, only consumed in IDLE. On a tie the master that was not
    // served last wins; otherwise the lone requester wins.
    logic              pick;
    logic              sel_wr_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_i_data;
    logic [BE_W-1:0]   sel_be;
    logic              owner_enable;

    always_comb begin
        pick         = m1_enable && (!m0_enable || !last_grant);
        sel_wr_en    = pick ? m1_wr_en  : m0_wr_en;
        sel_addr     = pick ? m1_addr   : m0_addr;
        sel_i_data   = pick ? m1_i_data : m0_i_data;
        sel_be       = pick ? m1_be     : m0_be;
        owner_enable = grant ? m1_enable : m0_enable;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            to_cnt     <= '0;
            grant      <= 1'b0;
            busy       <= 1'b0;
            s_enable   <= 1'b0;
            s_wr_en    <= 1'b0;
            s_addr     <= '0;
            s_i_data   <= '0;
            s_be       <= '0;
            m0_ready   <= 1'b0;
            m0_o_data  <= '0;
            m0_err     <= 1'b0;
            m1_ready   <= 1'b0;
            m1_o_data  <= '0;
            m1_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_enable || m1_enable) begin
                        grant      <= pick;
                        last_grant <= pick;
                        s_wr_en    <= sel_wr_en;
                        s_addr     <= sel_addr;
                        s_i_data   <= sel_i_data;
                        s_be       <= sel_be;
                        s_enable   <= 1'b1;
                        to_cnt     <= '0;
                        busy       <= 1'b1;
                        state      <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    // The owner dropping its enable here is ignored: the slave
                    // transaction always runs to completion or timeout.
                    to_cnt <= to_cnt + 1'b1;
                    if (s_ready) begin
                        s_enable <= 1'b0;
                        state    <= ST_DONE;
                        if (grant) begin
                            m1_o_data <= s_o_data;
                            m1_err    <= s_err;
                            m1_ready  <= 1'b1;
                        end else begin
                            m0_o_data <= s_o_data;
                            m0_err    <= s_err;
                            m0_ready  <= 1'b1;
                        end
                    end else if (TO_EN && (to_cnt == CNT_LAST)) begin
                        s_enable <= 1'b0;
                        state    <= ST_DONE;
                        if (grant) begin
                            m1_o_data <= '0;
                            m1_err    <= 1'b1;
                            m1_ready  <= 1'b1;
                        end else begin
                            m0_o_data <= '0;
                            m0_err    <= 1'b1;
                            m0_ready  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    // At least one cycle here guarantees the enable-low gap before
                    // the next grant can be made from IDLE.
                    if (!owner_enable) begin
                        m0_ready <= 1'b0;
                        m0_err   <= 1'b0;
                        m1_ready <= 1'b0;
                        m1_err   <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end

                default: begin
                    s_enable <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lt100_bus_arbiter.sv
// tb/tb_lt100_bus_arbiter.sv - directed self-checking bench for lt100_bus_arbiter
module tb_lt100_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_enable, m0_wr_en, m0_ready, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_i_data, m0_o_data;
    logic [BW-1:0] m0_be;
    logic          m1_enable, m1_wr_en, m1_ready, m1_err;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_i_data, m1_o_data;
    logic [BW-1:0] m1_be;
    logic          s_enable, s_wr_en, s_ready, s_err;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_i_data, s_o_data;
    logic [BW-1:0] s_be;
    logic          grant, busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    lt100_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_enable(m0_enable), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_i_data(m0_i_data),
        .m0_be(m0_be), .m0_ready(m0_ready), .m0_o_data(m0_o_data), .m0_err(m0_err),
        .m1_enable(m1_enable), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_i_data(m1_i_data),
        .m1_be(m1_be), .m1_ready(m1_ready), .m1_o_data(m1_o_data), .m1_err(m1_err),
        .s_enable(s_enable), .s_wr_en(s_wr_en), .s_addr(s_addr), .s_i_data(s_i_data),
        .s_be(s_be), .s_ready(s_ready), .s_o_data(s_o_data), .s_err(s_err),
        .grant(grant), .busy(busy)
    );

    // Slave model: answers slv_delay cycles after it first sees s_enable.
    int          slv_delay = 0;
    logic [31:0] slv_data  = 32'h0;
    logic        slv_err   = 1'b0;
    bit          slv_mute  = 1'b0;

    initial begin
        int scnt;
        scnt = 0;
        s_ready = 1'b0; s_o_data = '0; s_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (s_enable && !slv_mute) begin
                if (scnt == slv_delay) begin
                    s_ready = 1'b1; s_o_data = slv_data; s_err = slv_err;
                end else begin
                    s_ready = 1'b0; s_o_data = '0; s_err = 1'b0;
                end
                scnt++;
            end else begin
                s_ready = 1'b0; s_o_data = '0; s_err = 1'b0;
                if (!s_enable) scnt = 0;
            end
        end
    end

    // Bus monitor: grant order, enable-low gaps, enable-high run lengths, request
    // stability and stray readies on the non-owning master.
    int          grant_q[$];
    int          gap_q[$];
    int          en_len = 0;
    int          unstable = 0;
    int          stray_ready = 0;
    logic        rec_wr;
    logic [31:0] rec_addr, rec_data;
    logic [3:0]  rec_be;

    initial begin
        logic prev_en;
        int   low_run, high_run;
        prev_en = 1'b0; low_run = 0; high_run = 0;
        forever begin
            @(posedge clk); #1;
            if (s_enable && !prev_en) begin
                grant_q.push_back(int'(grant));
                gap_q.push_back(low_run);
                rec_wr = s_wr_en; rec_addr = s_addr; rec_data = s_i_data; rec_be = s_be;
            end else if (s_enable) begin
                if (s_wr_en !== rec_wr || s_addr !== rec_addr || s_i_data !== rec_data || s_be !== rec_be)
                    unstable++;
            end
            if ((m0_ready && grant !== 1'b0) || (m1_ready && grant !== 1'b1)) stray_ready++;
            if (s_enable) begin
                low_run = 0; high_run++;
            end else begin
                if (prev_en) en_len = high_run;
                high_run = 0; low_run++;
            end
            prev_en = s_enable;
        end
    end

    // Issues one transaction from master m; returns completion data and the number of
    // clock edges from raising enable to seeing mN_ready.
    task automatic txn(input int m, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int lat, output bit ok);
        logic rdy;
        int   n;
        ok = 1'b0; lat = 0; rdata = '0; err = 1'b0;
        if (m == 0) begin
            m0_wr_en = wr; m0_addr = addr; m0_i_data = wdata; m0_be = be; m0_enable = 1'b1;
        end else begin
            m1_wr_en = wr; m1_addr = addr; m1_i_data = wdata; m1_be = be; m1_enable = 1'b1;
        end
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1; n++;
            rdy = (m == 0) ? m0_ready : m1_ready;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        lat   = n;
        rdata = (m == 0) ? m0_o_data : m1_o_data;
        err   = (m == 0) ? m0_err : m1_err;
        if (m == 0) m0_enable = 1'b0; else m1_enable = 1'b0;
        n = 0;
        rdy = (m == 0) ? m0_ready : m1_ready;
        while (rdy && n < 10) begin
            @(posedge clk); #1; n++;
            rdy = (m == 0) ? m0_ready : m1_ready;
        end
        if (rdy) ok = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        m0_enable = 0; m0_wr_en = 0; m0_addr = '0; m0_i_data = '0; m0_be = '0;
        m1_enable = 0; m1_wr_en = 0; m1_addr = '0; m1_i_data = '0; m1_be = '0;
        do_reset();
        total++; if (s_enable !== 1'b0) $display("FAIL rst_s_enable: got %b expected 0", s_enable); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
        total++; if (grant !== 1'b0) $display("FAIL rst_grant: got %b expected 0", grant); else passed++;
        total++; if ({m0_ready, m1_ready, m0_err, m1_err} !== 4'b0)
            $display("FAIL rst_master_flags: got %b expected 0000", {m0_ready, m1_ready, m0_err, m1_err}); else passed++;
        total++; if (s_addr !== 32'h0 || m0_o_data !== 32'h0 || m1_o_data !== 32'h0)
            $display("FAIL rst_data: got addr %h d0 %h d1 %h expected 0", s_addr, m0_o_data, m1_o_data); else passed++;
    endtask

    task automatic test_single_read();
        logic [31:0] d; logic e; int l; bit k;
        slv_delay = 2; slv_data = 32'hDEADBEEF; slv_err = 1'b0; slv_mute = 1'b0;
        fork
            txn(0, 1'b0, 32'h10, 32'h0, 4'hF, d, e, l, k);
            begin
                #0;
                total++; if (s_enable !== 1'b0) $display("FAIL t1_no_comb_path: got %b expected 0", s_enable); else passed++;
                @(posedge clk); #1;
                total++; if (s_enable !== 1'b1 || s_addr !== 32'h10 || s_wr_en !== 1'b0)
                    $display("FAIL t1_issue: got en %b addr %h wr %b expected 1 00000010 0", s_enable, s_addr, s_wr_en); else passed++;
            end
        join
        total++; if (k !== 1'b1) $display("FAIL t1_complete: got %b expected 1", k); else passed++;
        total++; if (l !== 4) $display("FAIL t1_latency: got %0d expected 4", l); else passed++;
        total++; if (d !== 32'hDEADBEEF) $display("FAIL t1_rdata: got %h expected deadbeef", d); else passed++;
        total++; if (e !== 1'b0) $display("FAIL t1_err: got %b expected 0", e); else passed++;
    endtask

    task automatic test_tie_after_reset();
        logic [31:0] d0, d1; logic e0, e1; int l0, l1; bit k0, k1;
        do_reset();
        slv_delay = 0; slv_data = 32'h0000_1111;
        grant_q.delete(); gap_q.delete();
        fork
            txn(0, 1'b0, 32'h100, 32'h0, 4'hF, d0, e0, l0, k0);
            txn(1, 1'b0, 32'h200, 32'h0, 4'hF, d1, e1, l1, k1);
        join
        total++; if (k0 !== 1'b1 || k1 !== 1'b1) $display("FAIL t2_complete: got %b%b expected 11", k0, k1); else passed++;
        total++; if (l0 !== 2 || l1 !== 5) $display("FAIL t2_latency: got %0d,%0d expected 2,5", l0, l1); else passed++;
        total++; if (grant_q.size() !== 2) $display("FAIL t2_count: got %0d expected 2", grant_q.size());
        else begin
            passed++;
            total++; if (grant_q[0] !== 0 || grant_q[1] !== 1)
                $display("FAIL t2_order: got %0d,%0d expected 0,1", grant_q[0], grant_q[1]); else passed++;
            total++; if (gap_q[1] !== 2) $display("FAIL t2_gap: got %0d expected 2", gap_q[1]); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0, d1; logic e0, e1; int l0, l1; bit k0, k1; int bad;
        slv_delay = 1; slv_data = 32'h5A5A_0F0F;
        grant_q.delete(); gap_q.delete();
        bad = 0;
        fork
            for (int i = 0; i < 3; i++) begin
                txn(0, 1'b0, 32'h300 + 32'(i), 32'h0, 4'hF, d0, e0, l0, k0);
                if (!k0 || d0 !== 32'h5A5A_0F0F) bad++;
            end
            for (int j = 0; j < 3; j++) begin
                txn(1, 1'b0, 32'h400 + 32'(j), 32'h0, 4'hF, d1, e1, l1, k1);
                if (!k1 || d1 !== 32'h5A5A_0F0F) bad++;
            end
        join
        total++; if (bad !== 0) $display("FAIL t3_completions: got %0d bad expected 0", bad); else passed++;
        total++; if (grant_q.size() !== 6) $display("FAIL t3_count: got %0d expected 6", grant_q.size());
        else begin
            passed++;
            for (int i = 0; i < 6; i++) begin
                total++; if (grant_q[i] !== (i % 2)) $display("FAIL t3_grant_%0d: got %0d expected %0d", i, grant_q[i], i % 2); else passed++;
            end
            for (int i = 1; i < 6; i++) begin
                total++; if (gap_q[i] !== 2) $display("FAIL t3_gap_%0d: got %0d expected 2", i, gap_q[i]); else passed++;
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic e; int l; bit k;
        slv_mute = 1'b1;
        txn(1, 1'b0, 32'h500, 32'h0, 4'hF, d, e, l, k);
        total++; if (k !== 1'b1) $display("FAIL t4_complete: got %b expected 1", k); else passed++;
        total++; if (l !== 9) $display("FAIL t4_latency: got %0d expected 9", l); else passed++;
        total++; if (en_len !== 8) $display("FAIL t4_busy_cycles: got %0d expected 8", en_len); else passed++;
        total++; if (e !== 1'b1) $display("FAIL t4_err: got %b expected 1", e); else passed++;
        total++; if (d !== 32'h0) $display("FAIL t4_rdata: got %h expected 00000000", d); else passed++;
        slv_mute = 1'b0; slv_delay = 1; slv_data = 32'hCAFE_0001;
        txn(0, 1'b0, 32'h504, 32'h0, 4'hF, d, e, l, k);
        total++; if (k !== 1'b1 || e !== 1'b0 || d !== 32'hCAFE_0001 || l !== 3)
            $display("FAIL t4_recovery: got ok %b err %b data %h lat %0d expected 1 0 cafe0001 3", k, e, d, l); else passed++;
    endtask

    task automatic test_write_err();
        logic [31:0] d; logic e; int l; bit k; int unstable0;
        slv_delay = 3; slv_data = 32'h0; slv_err = 1'b1;
        unstable0 = unstable;
        txn(1, 1'b1, 32'h2000_0040, 32'hA5A5_1234, 4'b0110, d, e, l, k);
        slv_err = 1'b0;
        total++; if (k !== 1'b1 || l !== 5) $display("FAIL t5_complete: got ok %b lat %0d expected 1 5", k, l); else passed++;
        total++; if (e !== 1'b1) $display("FAIL t5_err: got %b expected 1", e); else passed++;
        total++; if (rec_wr !== 1'b1 || rec_addr !== 32'h2000_0040)
            $display("FAIL t5_wr_addr: got %b %h expected 1 20000040", rec_wr, rec_addr); else passed++;
        total++; if (rec_data !== 32'hA5A5_1234 || rec_be !== 4'b0110)
            $display("FAIL t5_data_be: got %h %b expected a5a51234 0110", rec_data, rec_be); else passed++;
        total++; if (unstable !== unstable0) $display("FAIL t5_stable: got %0d changes expected 0", unstable - unstable0); else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] d0, d1; logic e0, e1; int l0, l1; bit k0, k1; int n;
        slv_mute = 1'b1;
        m0_wr_en = 1'b0; m0_addr = 32'h600; m0_be = 4'hF; m0_enable = 1'b1;
        @(posedge clk); #1;
        total++; if (s_enable !== 1'b1 || busy !== 1'b1) $display("FAIL t6_in_busy: got en %b busy %b expected 1 1", s_enable, busy); else passed++;
        #3 rst = 1'b1;
        #1;
        total++; if (s_enable !== 1'b0 || busy !== 1'b0) $display("FAIL t6_async_en: got en %b busy %b expected 0 0", s_enable, busy); else passed++;
        total++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) $display("FAIL t6_async_ready: got %b%b expected 00", m0_ready, m1_ready); else passed++;
        m0_enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        slv_mute = 1'b0; slv_delay = 0; slv_data = 32'h7777_0000;
        grant_q.delete(); gap_q.delete();
        fork
            txn(0, 1'b0, 32'h700, 32'h0, 4'hF, d0, e0, l0, k0);
            txn(1, 1'b0, 32'h704, 32'h0, 4'hF, d1, e1, l1, k1);
        join
        total++; if (grant_q.size() < 1 || grant_q[0] !== 0)
            $display("FAIL t6_first_tie: got %0d entries first %0d expected m0 first", grant_q.size(), (grant_q.size() > 0) ? grant_q[0] : -1); else passed++;
        m0_addr = 32'h708; m0_enable = 1'b1;
        n = 0;
        while (!m0_ready && n < 20) begin @(posedge clk); #1; n++; end
        total++; if (m0_ready !== 1'b1) $display("FAIL t6_done_reached: got %b expected 1", m0_ready); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (m0_ready !== 1'b0 || m0_err !== 1'b0) $display("FAIL t6_async_done: got ready %b err %b expected 0 0", m0_ready, m0_err); else passed++;
        m0_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_isolation();
        total++; if (stray_ready !== 0) $display("FAIL stray_ready: got %0d cycles expected 0", stray_ready); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_tie_after_reset();
        test_back_to_back();
        test_timeout();
        test_write_err();
        test_async_reset();
        test_isolation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
